// File: rtl/rdyack_packer_pkg.sv
// Shared defaults and count-width helpers for the rdy/ack word packer.
package rdyack_packer_pkg;

  localparam int BW_DEF    = 16;
  localparam int NPACK_DEF = 4;

  // Width that can hold the values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W_DEF  = cnt_width(NPACK_DEF);
  localparam int DCNT_W_DEF = cnt_width(NPACK_DEF + 1);

endpackage

// File: rtl/rdyack_packer_oreg.sv
// Packed-word holding register and dst_rdy control for rdyack_packer.
// Optional word-count output under RDYACK_PACKER_LAST_EN.
module rdyack_packer_oreg #(
  parameter int W   = 64,
  parameter int DCW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [W-1:0]   load_dat,
`ifdef RDYACK_PACKER_LAST_EN
  input  logic [DCW-1:0] load_cnt,
  output logic [DCW-1:0] dst_cnt,
`endif
  input  logic           dst_ack,
  output logic           dst_rdy,
  output logic [W-1:0]   dst_dat
);

  // A load is only issued when the register is empty or draining this cycle,
  // so load takes priority and a simultaneous drain produces no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_rdy <= 1'b0;
      dst_dat <= '0;
    end else if (load) begin
      dst_rdy <= 1'b1;
      dst_dat <= load_dat;
    end else if (dst_rdy && dst_ack) begin
      dst_rdy <= 1'b0;
    end
  end

`ifdef RDYACK_PACKER_LAST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       dst_cnt <= '0;
    else if (load) dst_cnt <= load_cnt;
  end
`endif

endmodule

// File: rtl/rdyack_packer.sv
// Packs NPACK BW-bit words into one wide word over rdy/ack handshakes.
// Macro RDYACK_PACKER_LAST_EN adds src_last/dst_cnt for short groups.
//
// Handshake: a transfer happens on a rising edge where rdy && ack are both
// high; rdy never waits for ack, and the holder of rdy keeps data stable
// until the transfer cycle.
module rdyack_packer
  import rdyack_packer_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int NPACK = NPACK_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  src_rdy,
  output logic                  src_ack,
  input  logic [BW-1:0]         src_dat,
`ifdef RDYACK_PACKER_LAST_EN
  input  logic                  src_last,
  output logic [cnt_width(NPACK+1)-1:0] dst_cnt,
`endif
  output logic                  dst_rdy,
  input  logic                  dst_ack,
  output logic [BW*NPACK-1:0]   dst_dat
);

  localparam int CW  = cnt_width(NPACK);
  localparam int DCW = cnt_width(NPACK + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NPACK - 1);

  logic [CW-1:0]         cnt;
  logic [BW*NPACK-1:0]   acc;
  logic [BW*NPACK-1:0]   acc_ins;
  logic                  at_last;
  logic                  src_xfer;
  logic                  group_done;

`ifdef RDYACK_PACKER_LAST_EN
  assign at_last = (cnt == LAST_IDX) || src_last;
`else
  assign at_last = (cnt == LAST_IDX);
`endif

  // Only the group-completing word needs the output register free.
  assign src_ack    = src_rdy && !i_rst && (!at_last || !dst_rdy || dst_ack);
  assign src_xfer   = src_rdy && src_ack;
  assign group_done = src_xfer && at_last;

  // Slots above cnt are always zero in acc, which also zeroes short groups.
  always_comb begin
    acc_ins = acc;
    for (int k = 0; k < NPACK; k++) begin
      if (cnt == CW'(k)) acc_ins[k*BW +: BW] = src_dat;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (src_xfer) begin
      if (group_done) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        acc <= acc_ins;
      end
    end
  end

  rdyack_packer_oreg #(
    .W   (BW*NPACK),
    .DCW (DCW)
  ) u_oreg (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (group_done),
    .load_dat (acc_ins),
`ifdef RDYACK_PACKER_LAST_EN
    .load_cnt (DCW'(cnt) + DCW'(1)),
    .dst_cnt  (dst_cnt),
`endif
    .dst_ack  (dst_ack),
    .dst_rdy  (dst_rdy),
    .dst_dat  (dst_dat)
  );

endmodule

// File: doc/rdyack_packer.md
RDYACK_PACKER -- requirements
Module: rdyack_packer

Interface
REQ-001 SHALL have parameter BW, default 16, width of one input word.
REQ-002 SHALL have parameter NPACK, default 4, input words per packed output word (NPACK >= 2).
REQ-003 SHALL have port i_clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port src_rdy  input  1  upstream word valid.
REQ-006 SHALL have port src_ack  output  1  word accepted this cycle.
REQ-007 SHALL have port src_dat  input  BW  input word.
REQ-008 SHALL have port dst_rdy  output  1  packed word valid.
REQ-009 SHALL have port dst_ack  input  1  downstream accepts packed word.
REQ-010 SHALL have port dst_dat  output  BW*NPACK  packed word.

Function
REQ-011 SHALL treat a transfer as rdy && ack high in the same cycle on either channel.
REQ-012 SHALL hold dst_rdy high and dst_dat stable from assertion until the dst transfer cycle.
REQ-013 SHALL place the k-th accepted word of a group (k = 0..NPACK-1) in dst_dat[k*BW +: BW].
REQ-014 SHALL keep a word counter cnt of width $clog2(NPACK), incremented per src transfer, wrapping NPACK-1 -> 0.
REQ-015 SHALL drive src_ack = src_rdy && (cnt != NPACK-1 || !dst_rdy || dst_ack), combinationally.
REQ-016 SHALL assert dst_rdy on the cycle after the src transfer that completes a group; latency 1 cycle.
REQ-017 SHALL, when a dst transfer and a group completion coincide, load the new group and keep dst_rdy high with no bubble.
REQ-018 SHALL, when a dst transfer occurs with no group completion, deassert dst_rdy on the next cycle.
REQ-019 SHALL sustain one src transfer per cycle while dst_ack is held high.
REQ-020 SHALL continue accumulating words 0..NPACK-2 of the next group while dst_rdy waits, and stall only at the last word.

Reset
REQ-021 SHALL, on i_rst high, immediately clear cnt, accumulator, dst_rdy and dst_dat to 0, including mid-group; partial words are discarded.
REQ-022 SHALL accept no src transfer while i_rst is high (src_ack = 0).

Configuration
REQ-023 SHALL support macro RDYACK_PACKER_LAST_EN.
REQ-024 SHALL, with RDYACK_PACKER_LAST_EN defined, add src_last (input 1) and dst_cnt (output $clog2(NPACK+1)).
REQ-025 SHALL, with RDYACK_PACKER_LAST_EN defined, complete a group early on a src transfer with src_last = 1.
REQ-026 SHALL, for an early-completed group, set dst_cnt to the number of valid words, zero the unused slices of dst_dat, and reset cnt to 0.
REQ-027 SHALL, without RDYACK_PACKER_LAST_EN, omit src_last and dst_cnt and always emit exactly NPACK words per group.

Structure
REQ-028 SHALL take the BW/NPACK defaults and the count-width localparams from the shared package rdyack_packer_pkg.
REQ-029 SHALL implement the output holding register plus dst_rdy control as sub-module rdyack_packer_oreg; the counter and accumulator stay in the top module.

Verification
REQ-030 SHALL test basic operation: dst_ack held 1, send 16'h0001..16'h0004 back-to-back -> one dst transfer with dst_dat = 64'h0004_0003_0002_0001, one cycle after the 4th src transfer.
REQ-031 SHALL test backpressure: dst_ack = 0, send 8 words -> words 1-7 are accepted and src_ack drops on the 8th; asserting dst_ack for one cycle accepts the 8th in that same cycle and dst_rdy stays high.
REQ-032 SHALL test streaming: send 64 words with dst_ack held 1 -> 16 packed words with no src stall cycle and correct order.
REQ-033 SHALL test random stalls: random src_rdy/dst_ack at 50% for 1000 words -> output matches the scoreboard and dst_dat never changes while dst_rdy && !dst_ack.
REQ-034 SHALL test reset mid-group: 2 words accepted, then i_rst pulse -> dst_rdy = 0 and the next 4 words form the group starting at slice 0.
REQ-035 SHALL test, with RDYACK_PACKER_LAST_EN, words A,B with src_last on B -> dst_cnt = 2, dst_dat = {32'h0, B, A}.
